delta_sigma_dac_mc: RTL and testbench

DELTA_SIGMA_DAC_MC -- requirements
Module: delta_sigma_dac_mc

---
 rtl/delta_sigma_dac_mc.sv | 93 +++++++++
 tb/tb_delta_sigma_dac_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/delta_sigma_dac_mc.sv
// delta_sigma_dac_mc: multi-channel first/second-order delta-sigma DAC with a buffered sample handshake
module delta_sigma_dac_mc #(
  parameter int BW = 14,
  parameter int NCH = 2,
  parameter int DIV_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               mode_i,
  input  logic [DIV_W-1:0]   div_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [NCH*BW-1:0]  s_data_i,
  output logic [NCH-1:0]     dac_o,
  output logic               sat_o
);
  localparam int W = BW + 4;
  localparam logic signed [W+1:0] FB = {{(W+2-BW){1'b0}}, 1'b1, {(BW-1){1'b0}}};
  localparam logic signed [W+1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0] MINV = {3'b111, {(W-1){1'b0}}};
  logic [DIV_W-1:0] cnt;
  logic pend_full, mode_q, tick, xfer;
  logic [NCH*BW-1:0] pend, act, x_all;
  logic [NCH-1:0][BW-1:0] acc, acc_n;
  logic [NCH-1:0][W-1:0] i1, i2, i1_n, i2_n;
  logic [NCH-1:0] dac1_n, dac2_n, sat_n;
  assign tick = en_i && cnt == div_i;
  assign xfer = tick && pend_full;
  assign x_all = xfer ? pend : act;
  assign s_ready_o = !pend_full;
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [BW-1:0] x;
    logic [BW:0] s;
    logic signed [W+1:0] fb, a_raw, a, b_raw, b;
    // per-channel next state for both modulator orders, integrators clamped to W bits
    always_comb begin
      x = x_all[k*BW +: BW];
      s = {1'b0, acc[k]} + {1'b0, ~x[BW-1], x[BW-2:0]};
      fb = dac_o[k] ? FB : -FB;
      a_raw = {{2{i1[k][W-1]}}, i1[k]} + {{(W+2-BW){x[BW-1]}}, x} - fb;
      a = a_raw > MAXV ? MAXV : a_raw < MINV ? MINV : a_raw;
      b_raw = {{2{i2[k][W-1]}}, i2[k]} + a - fb;
      b = b_raw > MAXV ? MAXV : b_raw < MINV ? MINV : b_raw;
    end
    assign acc_n[k] = s[BW-1:0];
    assign dac1_n[k] = s[BW];
    assign i1_n[k] = a[W-1:0];
    assign i2_n[k] = b[W-1:0];
    assign dac2_n[k] = !b[W+1];
    assign sat_n[k] = a != a_raw || b != b_raw;
  end
  // tick counter, sample buffers and modulator state; a pending mode change costs one silent tick
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
      pend_full <= 1'b0;
      pend <= '0;
      act <= '0;
      mode_q <= 1'b0;
      acc <= '0;
      i1 <= '0;
      i2 <= '0;
      dac_o <= '0;
      sat_o <= 1'b0;
    end else begin
      cnt <= (!en_i || cnt >= div_i) ? '0 : cnt + 1'b1;
      if (xfer) begin
        act <= pend;
        pend_full <= 1'b0;
      end else if (s_valid_i && !pend_full) begin
        pend <= s_data_i;
        pend_full <= 1'b1;
      end
      if (!en_i || (tick && mode_i != mode_q)) begin
        acc <= '0;
        i1 <= '0;
        i2 <= '0;
        dac_o <= '0;
        mode_q <= mode_i;
        if (!en_i) sat_o <= 1'b0;
      end else if (tick && mode_q) begin
        i1 <= i1_n;
        i2 <= i2_n;
        dac_o <= dac2_n;
        sat_o <= sat_o | (|sat_n);
      end else if (tick) begin
        acc <= acc_n;
        dac_o <= dac1_n;
      end
    end
  end
endmodule

// File: tb/tb_delta_sigma_dac_mc.sv
// tb_delta_sigma_dac_mc: randomized self-checking bench against an integer reference model
module tb_delta_sigma_dac_mc;
  localparam int BW = 14, NCH = 2, DIV_W = 8;
  localparam int HALF = 1 << (BW - 1), FULL = 1 << BW;
  localparam longint IMAX = (longint'(1) <<< (BW + 3)) - 1;
  localparam longint IMIN = -(longint'(1) <<< (BW + 3));
  logic clk = 0, rst_i = 0, en_i = 0, mode_i = 0, s_valid_i = 0;
  logic [DIV_W-1:0] div_i = '0;
  logic [NCH*BW-1:0] s_data_i = '0;
  logic s_ready_o, sat_o;
  logic [NCH-1:0] dac_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  delta_sigma_dac_mc #(.BW(BW), .NCH(NCH), .DIV_W(DIV_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .mode_i(mode_i), .div_i(div_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .dac_o(dac_o), .sat_o(sat_o)
  );
  int m_cnt, m_pend[NCH], m_act[NCH], m_acc[NCH], t_x;
  bit m_pf, m_mode, m_sat, m_tick, t_xfer, t_acc;
  bit [NCH-1:0] m_dac;
  longint m_i1[NCH], m_i2[NCH], t_fb, t_a, t_b;
  // reference model: sample values as plain integers, density by carry-out and signed integrators
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_cnt = 0; m_pf = 0; m_mode = 0; m_sat = 0; m_dac = '0; m_tick = 0;
      for (int k = 0; k < NCH; k++) begin m_pend[k] = 0; m_act[k] = 0; m_acc[k] = 0; m_i1[k] = 0; m_i2[k] = 0; end
    end else begin
      m_tick = en_i && m_cnt == int'(div_i);
      t_xfer = m_tick && m_pf;
      t_acc = s_valid_i && !m_pf;
      if (!en_i) begin
        m_cnt = 0; m_sat = 0; m_dac = '0; m_mode = mode_i;
        for (int k = 0; k < NCH; k++) begin m_acc[k] = 0; m_i1[k] = 0; m_i2[k] = 0; end
      end else begin
        m_cnt = m_cnt >= int'(div_i) ? 0 : m_cnt + 1;
        if (m_tick) begin
          for (int k = 0; k < NCH; k++) begin
            t_x = t_xfer ? m_pend[k] : m_act[k];
            if (mode_i != m_mode) begin
              m_acc[k] = 0; m_i1[k] = 0; m_i2[k] = 0; m_dac[k] = 0;
            end else if (!m_mode) begin
              m_acc[k] = m_acc[k] + t_x + HALF;
              m_dac[k] = m_acc[k] >= FULL;
              m_acc[k] = m_acc[k] % FULL;
            end else begin
              t_fb = m_dac[k] ? HALF : -HALF;
              t_a = m_i1[k] + t_x - t_fb;
              if (t_a > IMAX) begin t_a = IMAX; m_sat = 1; end else if (t_a < IMIN) begin t_a = IMIN; m_sat = 1; end
              t_b = m_i2[k] + t_a - t_fb;
              if (t_b > IMAX) begin t_b = IMAX; m_sat = 1; end else if (t_b < IMIN) begin t_b = IMIN; m_sat = 1; end
              m_i1[k] = t_a; m_i2[k] = t_b; m_dac[k] = t_b >= 0;
            end
          end
          m_mode = mode_i;
        end
      end
      if (t_xfer) begin
        for (int k = 0; k < NCH; k++) m_act[k] = m_pend[k];
        m_pf = 0;
      end else if (t_acc) begin
        for (int k = 0; k < NCH; k++) m_pend[k] = int'($signed(s_data_i[k*BW +: BW]));
        m_pf = 1;
      end
    end
  end
  function automatic logic [NCH*BW-1:0] mk(input int c0, input int c1);
    return {BW'(c1), BW'(c0)};
  endfunction
  function automatic int rs();
    return int'($urandom_range(FULL - 1)) - HALF;
  endfunction
  task automatic put(input logic [NCH*BW-1:0] d);
    @(negedge clk); s_data_i = d; s_valid_i = 1;
    @(negedge clk); s_valid_i = 0;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests += 3;
    if (dac_o !== 2'b00) begin fails++; $display("FAIL reset_dac got=%b exp=00", dac_o); end
    if (sat_o !== 1'b0) begin fails++; $display("FAIL reset_sat got=%b exp=0", sat_o); end
    if (s_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", s_ready_o); end
    rst_i = 1; en_i = 1;
  endtask
  task automatic test_first_order();
    logic prev = 0;
    put(mk(0, rs()));
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL fo_model cyc=%0d got=%b%b%b exp=%b%b%b", i, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (i >= 2) begin tests++; if (dac_o[0] === prev) begin fails++; $display("FAIL fo_alternate cyc=%0d got=%b exp=%b", i, dac_o[0], !prev); end end
      prev = dac_o[0];
    end
  endtask
  task automatic test_extremes();
    int zeros = 0;
    put(mk(-HALF, rs()));
    for (int i = 0; i < 64; i++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL min_model cyc=%0d got=%b%b%b exp=%b%b%b", i, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (i >= 2) begin tests++; if (dac_o[0] !== 1'b0) begin fails++; $display("FAIL min_zero cyc=%0d got=%b exp=0", i, dac_o[0]); end end
    end
    put(mk(HALF - 1, rs()));
    for (int i = 0; i < FULL + 2; i++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL max_model cyc=%0d got=%b%b%b exp=%b%b%b", i, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (i >= 2 && dac_o[0] === 1'b0) zeros++;
    end
    tests++;
    if (zeros != 1) begin fails++; $display("FAIL max_one_zero got=%0d exp=1", zeros); end
  endtask
  task automatic test_handshake();
    int last = 0, n = 0, low = 0;
    logic rdy;
    @(negedge clk); div_i = 3; s_valid_i = 1; s_data_i = mk(rs(), rs()); rdy = s_ready_o;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL hs_model cyc=%0d got=%b%b%b exp=%b%b%b", c, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (rdy) begin
        if (n >= 2) begin tests++; if (c - last != 4) begin fails++; $display("FAIL hs_interval got=%0d exp=4", c - last); end end
        last = c; n++; s_data_i = mk(rs(), rs());
      end
      if (!s_ready_o) low++;
      else if (low != 0) begin
        tests++;
        if (low > 4) begin fails++; $display("FAIL hs_low_len got=%0d exp=1..4", low); end
        low = 0;
      end
      rdy = s_ready_o;
    end
    tests++;
    if (n < 10) begin fails++; $display("FAIL hs_accepts got=%0d exp>=10", n); end
    s_valid_i = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL hs_drain cyc=%0d got=%b%b%b exp=%b%b%b", c, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
    end
  endtask
  task automatic test_div_change();
    div_i = 9;
    put(mk(rs(), rs()));
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL div_model cyc=%0d got=%b%b%b exp=%b%b%b", c, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (c == 6 || c == 25) div_i = DIV_W'($urandom_range(3));
    end
  endtask
  task automatic test_enable();
    @(negedge clk); en_i = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); tests += 2;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL en_model cyc=%0d got=%b%b%b exp=%b%b%b", c, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if ({dac_o, sat_o} !== 3'b000) begin fails++; $display("FAIL en_off got=%b%b exp=000", dac_o, sat_o); end
      s_valid_i = c == 1; s_data_i = mk(rs(), rs());
    end
    en_i = 1; div_i = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL en_resume cyc=%0d got=%b%b%b exp=%b%b%b", c, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
    end
  endtask
  task automatic test_second_order();
    int ones = 0;
    @(negedge clk); mode_i = 1; div_i = 0;
    put(mk(4096, int'($urandom_range(4096)) - 2048));
    for (int i = 0; i < 65536 + 8; i++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL so_model cyc=%0d got=%b%b%b exp=%b%b%b", i, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (i >= 8) ones += int'(dac_o[0]);
    end
    tests += 2;
    if (ones < 49152 - 327 || ones > 49152 + 327) begin fails++; $display("FAIL so_density got=%0d exp=49152+-327", ones); end
    if (sat_o !== 1'b0) begin fails++; $display("FAIL so_sat got=%b exp=0", sat_o); end
  endtask
  task automatic test_mode_toggle();
    bit seen = 0;
    @(negedge clk); div_i = 3; mode_i = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      if (m_tick) begin
        seen = 1; tests++;
        if (dac_o !== 2'b00) begin fails++; $display("FAIL mode_tick_dac got=%b exp=00", dac_o); end
      end
    end
    tests++;
    if (!seen) begin fails++; $display("FAIL mode_tick_timeout got=none exp=tick"); end
    for (int c = 0; c < 32; c++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL mode_model cyc=%0d got=%b%b%b exp=%b%b%b", c, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (c == 12) mode_i = 1;
      if (c == 24) mode_i = 0;
    end
  endtask
  task automatic test_async_reset();
    logic [NCH-1:0] prev = '0;
    div_i = 200;
    put(mk(-HALF, -HALF));
    tests++;
    if (s_ready_o !== 1'b0) begin fails++; $display("FAIL ar_pending got=%b exp=0", s_ready_o); end
    #2 rst_i = 0;
    #1 tests += 3;
    if (dac_o !== 2'b00) begin fails++; $display("FAIL ar_dac got=%b exp=00", dac_o); end
    if (sat_o !== 1'b0) begin fails++; $display("FAIL ar_sat got=%b exp=0", sat_o); end
    if (s_ready_o !== 1'b1) begin fails++; $display("FAIL ar_ready got=%b exp=1", s_ready_o); end
    @(negedge clk); rst_i = 1; div_i = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); tests++;
      if ({dac_o, s_ready_o, sat_o} !== {m_dac, !m_pf, m_sat}) begin fails++; $display("FAIL ar_model cyc=%0d got=%b%b%b exp=%b%b%b", i, dac_o, s_ready_o, sat_o, m_dac, !m_pf, m_sat); end
      if (i >= 2) begin tests++; if (dac_o !== ~prev) begin fails++; $display("FAIL ar_lost_set cyc=%0d got=%b exp=%b", i, dac_o, ~prev); end end
      prev = dac_o;
    end
  endtask
  initial begin
    test_reset();
    test_first_order();
    test_extremes();
    test_handshake();
    test_div_change();
    test_enable();
    test_second_order();
    test_mode_toggle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
